// File: rtl/output_buffer.sv
// Memory-mapped output peripheral: LEDR/LEDG/HEX0-7/LCD registers with byte-lane stores and combinational readback.
// Optional feature macro: OUT_WR_STROBE_EN adds the registered o_ledr_wr pulse.
module output_buffer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7000,
    parameter logic [6:0]  HEX_RST   = 7'h7F
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lsu_addr,
    input  logic        i_lsu_wren,
    input  logic [31:0] i_st_data,
    input  logic [3:0]  i_bmask,
    output logic        o_hit,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd
`ifdef OUT_WR_STROBE_EN
    ,
    output logic        o_ledr_wr
`endif
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LANES   = 4;
    localparam int unsigned HEX_W   = 7;
    localparam int unsigned N_HEX   = 8;
    localparam int unsigned WOFF_W  = 6;

    localparam logic [WOFF_W-1:0] WOFF_LEDR   = 6'h00;
    localparam logic [WOFF_W-1:0] WOFF_LEDG   = 6'h04;
    localparam logic [WOFF_W-1:0] WOFF_HEX_LO = 6'h08;
    localparam logic [WOFF_W-1:0] WOFF_HEX_HI = 6'h09;
    localparam logic [WOFF_W-1:0] WOFF_LCD    = 6'h0C;

    logic [DATA_W-1:0] ledr_q;
    logic [DATA_W-1:0] ledg_q;
    logic [DATA_W-1:0] lcd_q;
    logic [HEX_W-1:0]  hex_q [N_HEX];

    logic [WOFF_W-1:0] woff;
    logic              wr_en;
    logic              sel_ledr;
    logic              sel_ledg;
    logic              sel_hex_lo;
    logic              sel_hex_hi;
    logic              sel_lcd;
    logic              unused_addr_bits;

    // Region and word decode; byte offset bits within a word carry no meaning.
    assign o_hit            = (i_lsu_addr[31:8] == BASE_ADDR[31:8]);
    assign woff             = i_lsu_addr[7:2];
    assign unused_addr_bits = ^i_lsu_addr[1:0];
    assign wr_en            = i_lsu_wren & o_hit;

    assign sel_ledr   = (woff == WOFF_LEDR);
    assign sel_ledg   = (woff == WOFF_LEDG);
    assign sel_hex_lo = (woff == WOFF_HEX_LO);
    assign sel_hex_hi = (woff == WOFF_HEX_HI);
    assign sel_lcd    = (woff == WOFF_LCD);

    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [LANES-1:0]  mask
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(LANES); i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Word-wide registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ledr_q <= '0;
            ledg_q <= '0;
            lcd_q  <= '0;
        end else if (wr_en) begin
            if (sel_ledr) ledr_q <= merge_lanes(ledr_q, i_st_data, i_bmask);
            if (sel_ledg) ledg_q <= merge_lanes(ledg_q, i_st_data, i_bmask);
            if (sel_lcd)  lcd_q  <= merge_lanes(lcd_q, i_st_data, i_bmask);
        end
    end

    // HEX digits: lane n of the low/high word feeds digit n / n+4; lane bit 7 is dropped.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < int'(N_HEX); i++) begin
                hex_q[i] <= HEX_RST;
            end
        end else if (wr_en && (sel_hex_lo || sel_hex_hi)) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (i_bmask[i]) begin
                    if (sel_hex_lo) hex_q[i]     <= i_st_data[8*i +: HEX_W];
                    if (sel_hex_hi) hex_q[i + 4] <= i_st_data[8*i +: HEX_W];
                end
            end
        end
    end

    // Combinational readback of pre-edge register contents.
    always_comb begin
        o_ld_data = '0;
        if (o_hit) begin
            case (woff)
                WOFF_LEDR:   o_ld_data = ledr_q;
                WOFF_LEDG:   o_ld_data = ledg_q;
                WOFF_HEX_LO: o_ld_data = {1'b0, hex_q[3], 1'b0, hex_q[2],
                                          1'b0, hex_q[1], 1'b0, hex_q[0]};
                WOFF_HEX_HI: o_ld_data = {1'b0, hex_q[7], 1'b0, hex_q[6],
                                          1'b0, hex_q[5], 1'b0, hex_q[4]};
                WOFF_LCD:    o_ld_data = lcd_q;
                default:     o_ld_data = '0;
            endcase
        end
    end

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;
    assign o_io_hex0 = hex_q[0];
    assign o_io_hex1 = hex_q[1];
    assign o_io_hex2 = hex_q[2];
    assign o_io_hex3 = hex_q[3];
    assign o_io_hex4 = hex_q[4];
    assign o_io_hex5 = hex_q[5];
    assign o_io_hex6 = hex_q[6];
    assign o_io_hex7 = hex_q[7];

`ifdef OUT_WR_STROBE_EN
    logic ledr_wr_q;

    // One-cycle pulse per accepted LEDR store touching the character lane.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ledr_wr_q <= 1'b0;
        end else begin
            ledr_wr_q <= wr_en & sel_ledr & i_bmask[0];
        end
    end

    assign o_ledr_wr = ledr_wr_q;
`endif

endmodule

// File: tb/tb_output_buffer.sv
// Directed self-checking bench for output_buffer; covers the strobe when OUT_WR_STROBE_EN is defined.
module tb_output_buffer;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        wren;
    logic [31:0] st_data;
    logic [3:0]  bmask;
    logic        hit;
    logic [31:0] ld_data;
    logic [31:0] ledr;
    logic [31:0] ledg;
    logic [31:0] lcd;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
`ifdef OUT_WR_STROBE_EN
    logic        ledr_wr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    output_buffer dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_lsu_addr (addr),
        .i_lsu_wren (wren),
        .i_st_data  (st_data),
        .i_bmask    (bmask),
        .o_hit      (hit),
        .o_ld_data  (ld_data),
        .o_io_ledr  (ledr),
        .o_io_ledg  (ledg),
        .o_io_hex0  (hex0),
        .o_io_hex1  (hex1),
        .o_io_hex2  (hex2),
        .o_io_hex3  (hex3),
        .o_io_hex4  (hex4),
        .o_io_hex5  (hex5),
        .o_io_hex6  (hex6),
        .o_io_hex7  (hex7),
        .o_io_lcd   (lcd)
`ifdef OUT_WR_STROBE_EN
        ,
        .o_ledr_wr  (ledr_wr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        addr    = a;
        st_data = d;
        bmask   = m;
        wren    = 1'b1;
        @(posedge clk);
        #1;
        wren  = 1'b0;
        bmask = 4'h0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        wren = 1'b0;
        addr = a;
        #1;
        d = ld_data;
    endtask

    logic [31:0] rd;

    initial begin
        rst_n   = 1'b0;
        addr    = 32'h0;
        wren    = 1'b0;
        st_data = 32'h0;
        bmask   = 4'h0;
        repeat (2) @(posedge clk);
        #1;

        check("rst_ledr", ledr, 32'h0);
        check("rst_ledg", ledg, 32'h0);
        check("rst_lcd",  lcd,  32'h0);
        check("rst_hex0", 32'(hex0), 32'h7F);
        check("rst_hex3", 32'(hex3), 32'h7F);
        check("rst_hex7", 32'(hex7), 32'h7F);
        load(32'h7020, rd); check("rst_rd_hexlo", rd, 32'h7F7F7F7F);
        load(32'h7024, rd); check("rst_rd_hexhi", rd, 32'h7F7F7F7F);
`ifdef OUT_WR_STROBE_EN
        check("rst_strobe", 32'(ledr_wr), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Word store: readback before the edge still shows the old value.
        @(negedge clk);
        addr = 32'h7000; st_data = 32'h0000_0048; bmask = 4'hF; wren = 1'b1;
        #1;
        check("pre_edge_rd", ld_data, 32'h0);
        check("pre_edge_hit", 32'(hit), 32'h1);
        @(posedge clk);
        #1;
        wren = 1'b0;
        check("ledr_word", ledr, 32'h48);
        load(32'h7000, rd); check("rd_ledr", rd, 32'h48);
        load(32'h7003, rd); check("rd_ledr_lowbits", rd, 32'h48);

        // Byte lanes on LCD.
        store(32'h7030, 32'h11223344, 4'hF);
        store(32'h7030, 32'hAABBCCDD, 4'b0101);
        check("lcd_lanes", lcd, 32'h11BB33DD);
        load(32'h7030, rd); check("rd_lcd", rd, 32'h11BB33DD);

        // HEX high word mapping; bit 7 of each lane dropped.
        store(32'h7024, 32'h80FF4079, 4'hF);
        check("hex4", 32'(hex4), 32'h79);
        check("hex5", 32'(hex5), 32'h40);
        check("hex6", 32'(hex6), 32'h7F);
        check("hex7", 32'(hex7), 32'h00);
        load(32'h7024, rd); check("rd_hexhi", rd, 32'h007F4079);
        check("hex0_kept", 32'(hex0), 32'h7F);

        // Single lane into HEX1.
        store(32'h7020, 32'h0000_3F00, 4'b0010);
        check("hex1", 32'(hex1), 32'h3F);
        load(32'h7020, rd); check("rd_hexlo", rd, 32'h7F7F3F7F);

        // Unmapped offset inside region.
        store(32'h7008, 32'hFFFFFFFF, 4'hF);
        load(32'h7008, rd);
        check("unmap_rd", rd, 32'h0);
        check("unmap_hit", 32'(hit), 32'h1);
        check("unmap_ledr", ledr, 32'h48);
        check("unmap_lcd", lcd, 32'h11BB33DD);

        // Outside the region, including an offset that aliases LEDR.
        store(32'h8000, 32'hDEADBEEF, 4'hF);
        load(32'h8000, rd);
        check("oor_rd", rd, 32'h0);
        check("oor_hit", 32'(hit), 32'h0);
        check("oor_ledr", ledr, 32'h48);
        load(32'h7100, rd);
        check("oor_hit_7100", 32'(hit), 32'h0);

        // Empty mask is a no-op; partial LEDG store.
        store(32'h7010, 32'hFFFFFFFF, 4'h0);
        check("ledg_nomask", ledg, 32'h0);
        store(32'h7010, 32'h12345678, 4'b1100);
        check("ledg_hi", ledg, 32'h12340000);

`ifdef OUT_WR_STROBE_EN
        @(posedge clk); #1;
        check("strobe_idle", 32'(ledr_wr), 32'h0);
        store(32'h7000, 32'h41, 4'b0001);
        check("strobe_1", 32'(ledr_wr), 32'h1);
        store(32'h7000, 32'h41, 4'b0001);
        check("strobe_2", 32'(ledr_wr), 32'h1);
        @(posedge clk); #1;
        check("strobe_end", 32'(ledr_wr), 32'h0);
        store(32'h7010, 32'h41, 4'b0001);
        check("strobe_ledg", 32'(ledr_wr), 32'h0);
        store(32'h7000, 32'h4100, 4'b0010);
        check("strobe_lane1", 32'(ledr_wr), 32'h0);
        check("ledr_lane1", ledr, 32'h4141);
`endif

        // Reset dropped between edges during a LEDR store.
        @(negedge clk);
        addr = 32'h7000; st_data = 32'h55; bmask = 4'hF; wren = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ledr", ledr, 32'h0);
        check("async_lcd", lcd, 32'h0);
        @(posedge clk); #1;
        check("async_ledr_edge", ledr, 32'h0);
        check("async_hex4", 32'(hex4), 32'h7F);
`ifdef OUT_WR_STROBE_EN
        check("async_strobe", 32'(ledr_wr), 32'h0);
`endif
        @(negedge clk);
        wren  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ledr", ledr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
